// File: rtl/gate_bist.sv
// BIST sequencer for two-input gate wrappers: drives LFSR operand pairs into a
// gate under test and checks each response against the expected NAND result.
module gate_bist #(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned NUM_VECTORS = 256,
    parameter int unsigned DUT_LAT     = 0,
    parameter logic [31:0] SEED        = 32'hACE1_5EED,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] fail_count,
    output logic [15:0]      first_fail_idx,
    output logic [WIDTH-1:0] dut_in1,
    output logic [WIDTH-1:0] dut_in2,
    input  logic [WIDTH-1:0] dut_out
);

    localparam int unsigned IDX_W      = 16;
    localparam logic [31:0] TAPS       = 32'h8020_0003;
    localparam logic [IDX_W-1:0] LAST_VEC = IDX_W'(NUM_VECTORS - 1);
    localparam logic [1:0]  LAST_DRAIN = 2'((DUT_LAT > 0) ? DUT_LAT - 1 : 0);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    // One entry of the expected-value delay line
    typedef struct packed {
        logic             vld;
        logic [IDX_W-1:0] idx;
        logic [WIDTH-1:0] exp;
    } chk_t;

    state_t             state, state_nxt;
    logic [31:0]        lfsr, lfsr_src, lfsr_step;
    logic [IDX_W-1:0]   vcnt;
    logic [1:0]         dcnt;
    logic [CNT_W-1:0]   fail_nxt;
    logic [IDX_W-1:0]   ffi_nxt;
    logic               accept;
    logic               mis_c;
    chk_t               chk_c, chk_d;

    // Vector 0 comes straight from SEED, so the source is SEED while idle
    always_comb begin
        lfsr_src  = (state == IDLE) ? SEED : lfsr;
        lfsr_step = lfsr_src[0] ? ((lfsr_src >> 1) ^ TAPS) : (lfsr_src >> 1);
    end

    always_comb begin
        chk_c.vld = (state == RUN);
        chk_c.idx = vcnt;
        chk_c.exp = ~(dut_in1 & dut_in2);
    end

    generate
        if (DUT_LAT == 0) begin : g_nolat
            assign chk_d = chk_c;
        end else begin : g_lat
            chk_t pipe [DUT_LAT];
            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int i = 0; i < int'(DUT_LAT); i++) pipe[i] <= '0;
                end else begin
                    pipe[0] <= chk_c;
                    for (int i = 1; i < int'(DUT_LAT); i++) pipe[i] <= pipe[i-1];
                end
            end
            assign chk_d = pipe[DUT_LAT-1];
        end
    endgenerate

    assign accept = (state == IDLE) && start;
    assign mis_c  = chk_d.vld && (dut_out != chk_d.exp);

    // Next state plus next values of the fail statistics
    always_comb begin
        state_nxt = state;
        fail_nxt  = fail_count;
        ffi_nxt   = first_fail_idx;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (vcnt == LAST_VEC) state_nxt = (DUT_LAT > 0) ? DRAIN : DONE;
            DRAIN:   if (dcnt == LAST_DRAIN) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (accept) begin
            fail_nxt = '0;
            ffi_nxt  = '0;
        end else if (mis_c) begin
            if (fail_count != CNT_MAX) fail_nxt = fail_count + CNT_W'(1);
            if (fail_count == '0)      ffi_nxt  = chk_d.idx;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            lfsr           <= SEED;
            vcnt           <= '0;
            dcnt           <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
            fail_count     <= '0;
            first_fail_idx <= '0;
            dut_in1        <= '0;
            dut_in2        <= '0;
        end else begin
            state          <= state_nxt;
            busy           <= (state_nxt == RUN) || (state_nxt == DRAIN);
            done           <= (state_nxt == DONE);
            fail_count     <= fail_nxt;
            first_fail_idx <= ffi_nxt;
            vcnt           <= (state == RUN) ? vcnt + IDX_W'(1) : '0;
            dcnt           <= (state == DRAIN) ? dcnt + 2'd1 : 2'd0;
            if (state_nxt == RUN) begin
                dut_in1 <= lfsr_src[WIDTH-1:0];
                dut_in2 <= lfsr_src[31:32-WIDTH];
                lfsr    <= lfsr_step;
            end else begin
                dut_in1 <= '0;
                dut_in2 <= '0;
            end
            if (accept)
                pass <= 1'b0;
            else if (state_nxt == DONE)
                pass <= (fail_nxt == '0);
        end
    end

endmodule

// File: tb/tb_gate_bist.sv
// Directed bench for gate_bist: good, stuck-at, latency-mismatched and
// saturating gate models, plus restart and mid-run reset behaviour.
module tb_gate_bist;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic s0 = 1'b0, s1 = 1'b0, s2 = 1'b0, s3 = 1'b0;
    int   mode = 0;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    logic        b0, d0, p0, b1, d1, p1, b2, d2, p2, b3, d3, p3;
    logic [15:0] fc0, ff0, fc1, ff1, fc2, ff2, ff3;
    logic [1:0]  fc3;
    logic [3:0]  a0, c0, o0, a1, c1, o1, a2, c2, o2, a3, c3;
    logic [3:0]  r1a, r1b, r2a, r2b;

    // Combinational NAND; mode 1 holds output bit 2 at 0
    assign o0 = (mode == 0) ? ~(a0 & c0) : (~(a0 & c0) & 4'b1011);

    // Two-stage registered NAND models
    always_ff @(posedge clk) begin
        if (rst) begin
            r1a <= '0; r1b <= '0; r2a <= '0; r2b <= '0;
        end else begin
            r1a <= ~(a1 & c1); r1b <= r1a;
            r2a <= ~(a2 & c2); r2b <= r2a;
        end
    end
    assign o1 = r1b;
    assign o2 = r2b;

    gate_bist #(.WIDTH(4), .NUM_VECTORS(16), .DUT_LAT(0), .CNT_W(16)) u0 (
        .clk(clk), .rst(rst), .start(s0), .busy(b0), .done(d0), .pass(p0),
        .fail_count(fc0), .first_fail_idx(ff0), .dut_in1(a0), .dut_in2(c0), .dut_out(o0));

    gate_bist #(.WIDTH(4), .NUM_VECTORS(8), .DUT_LAT(2), .CNT_W(16)) u1 (
        .clk(clk), .rst(rst), .start(s1), .busy(b1), .done(d1), .pass(p1),
        .fail_count(fc1), .first_fail_idx(ff1), .dut_in1(a1), .dut_in2(c1), .dut_out(o1));

    gate_bist #(.WIDTH(4), .NUM_VECTORS(8), .DUT_LAT(1), .CNT_W(16)) u2 (
        .clk(clk), .rst(rst), .start(s2), .busy(b2), .done(d2), .pass(p2),
        .fail_count(fc2), .first_fail_idx(ff2), .dut_in1(a2), .dut_in2(c2), .dut_out(o2));

    gate_bist #(.WIDTH(4), .NUM_VECTORS(16), .DUT_LAT(0), .CNT_W(2)) u3 (
        .clk(clk), .rst(rst), .start(s3), .busy(b3), .done(d3), .pass(p3),
        .fail_count(fc3), .first_fail_idx(ff3), .dut_in1(a3), .dut_in2(c3), .dut_out(4'h0));

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: mismatches of the bit-2-stuck-at-0 NAND over the first n vectors
    function automatic int count_fails(input int n, output int first);
        logic [31:0] l;
        logic [3:0]  a, b, e;
        int          c;
        l     = 32'hACE1_5EED;
        c     = 0;
        first = -1;
        for (int k = 0; k < n; k++) begin
            a = l[3:0];
            b = l[31:28];
            e = ~(a & b);
            if (e[2]) begin
                if (c == 0) first = k;
                c++;
            end
            l = l[0] ? ((l >> 1) ^ 32'h8020_0003) : (l >> 1);
        end
        return c;
    endfunction

    initial begin
        int exp_cnt, exp_first, part, dummy, seen;
        exp_cnt = count_fails(16, exp_first);

        // Reset state
        tick(3);
        check("rst_busy", 32'(b0), 32'd0);
        check("rst_done", 32'(d0), 32'd0);
        check("rst_pass", 32'(p0), 32'd0);
        check("rst_fc", 32'(fc0), 32'd0);
        check("rst_ffi", 32'(ff0), 32'd0);
        check("rst_in1", 32'(a0), 32'd0);
        check("rst_in2", 32'(c0), 32'd0);
        rst = 1'b0;
        tick(1);

        // Good combinational NAND
        mode = 0;
        s0 = 1'b1; tick(1); s0 = 1'b0;
        check("good_busy_c1", 32'(b0), 32'd1);
        check("good_in1_v0", 32'(a0), 32'hD);
        check("good_in2_v0", 32'(c0), 32'hA);
        tick(1);
        check("good_in1_v1", 32'(a0), 32'h5);
        check("good_in2_v1", 32'(c0), 32'hD);
        tick(14);
        check("good_busy_c16", 32'(b0), 32'd1);
        check("good_done_c16", 32'(d0), 32'd0);
        tick(1);
        check("good_busy_c17", 32'(b0), 32'd0);
        check("good_done_c17", 32'(d0), 32'd1);
        check("good_pass", 32'(p0), 32'd1);
        check("good_fc", 32'(fc0), 32'd0);
        tick(1);
        check("good_done_c18", 32'(d0), 32'd0);
        check("good_pass_sticky", 32'(p0), 32'd1);

        // Output bit 2 stuck at 0
        mode = 1;
        s0 = 1'b1; tick(1); s0 = 1'b0;
        check("sa_pass_clr", 32'(p0), 32'd0);
        check("sa_fc_clr", 32'(fc0), 32'd0);
        tick(16);
        check("sa_done", 32'(d0), 32'd1);
        check("sa_fc", 32'(fc0), 32'(exp_cnt));
        check("sa_ffi", 32'(ff0), 32'(exp_first));
        check("sa_pass", 32'(p0), 32'd0);
        tick(1);

        // start re-pulsed during RUN is ignored
        s0 = 1'b1; tick(1); s0 = 1'b0;
        tick(2);
        s0 = 1'b1; tick(1); s0 = 1'b0;
        part = count_fails(3, dummy);
        check("rp_fc_c4", 32'(fc0), 32'(part));
        tick(12);
        check("rp_busy_c16", 32'(b0), 32'd1);
        check("rp_done_c16", 32'(d0), 32'd0);
        tick(1);
        check("rp_done_c17", 32'(d0), 32'd1);
        check("rp_fc", 32'(fc0), 32'(exp_cnt));
        tick(1);

        // Reset in RUN cycle 5
        s0 = 1'b1; tick(1); s0 = 1'b0;
        tick(4);
        part = count_fails(4, dummy);
        check("mr_fc_c5", 32'(fc0), 32'(part));
        rst = 1'b1; tick(1); rst = 1'b0;
        check("mr_busy", 32'(b0), 32'd0);
        check("mr_in1", 32'(a0), 32'd0);
        check("mr_in2", 32'(c0), 32'd0);
        check("mr_fc", 32'(fc0), 32'd0);
        check("mr_done", 32'(d0), 32'd0);
        seen = 0;
        repeat (14) begin
            tick(1);
            if (d0 !== 1'b0) seen++;
        end
        check("mr_no_done", 32'(seen), 32'd0);
        s0 = 1'b1; tick(1); s0 = 1'b0;
        check("mr_restart_in1", 32'(a0), 32'hD);
        check("mr_restart_in2", 32'(c0), 32'hA);
        tick(17);

        // Two-stage DUT with DUT_LAT=2 (matched) and DUT_LAT=1 (mismatched)
        s1 = 1'b1; s2 = 1'b1; tick(1); s1 = 1'b0; s2 = 1'b0;
        tick(9);
        check("l2_busy_c10", 32'(b1), 32'd1);
        check("l2_done_c10", 32'(d1), 32'd0);
        check("l1_done_c10", 32'(d2), 32'd1);
        check("l1_busy_c10", 32'(b2), 32'd0);
        check("l1_pass", 32'(p2), 32'd0);
        check("l1_fc_nz", 32'(fc2 != 16'd0), 32'd1);
        check("l1_ffi", 32'(ff2), 32'd0);
        tick(1);
        check("l2_done_c11", 32'(d1), 32'd1);
        check("l2_pass", 32'(p1), 32'd1);
        check("l2_fc", 32'(fc1), 32'd0);
        check("l2_ffi", 32'(ff1), 32'd0);
        check("l1_done_c11", 32'(d2), 32'd0);
        tick(2);

        // Saturating 2-bit fail counter, DUT output tied low
        s3 = 1'b1; tick(1); s3 = 1'b0;
        check("sat_in1_v0", 32'(a3), 32'hD);
        check("sat_in2_v0", 32'(c3), 32'hA);
        check("sat_busy", 32'(b3), 32'd1);
        tick(16);
        check("sat_done", 32'(d3), 32'd1);
        check("sat_fc", 32'(fc3), 32'd3);
        check("sat_ffi", 32'(ff3), 32'd0);
        check("sat_pass", 32'(p3), 32'd0);
        tick(2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
